// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword geometry, parity masks, FSM encoding
// and the reference encoder used by both the transmitter and decoder-side models.
package hamming_pkg;

    localparam int CW_BITS   = 7;
    localparam int DATA_BITS = 4;

    // Bit i of a mask covers codeword position i+1.
    localparam logic [CW_BITS-1:0] P1_MASK = 7'b1010101;
    localparam logic [CW_BITS-1:0] P2_MASK = 7'b1100110;
    localparam logic [CW_BITS-1:0] P4_MASK = 7'b1111000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [CW_BITS-1:0] hamming74_encode(input logic [DATA_BITS-1:0] d);
        logic [CW_BITS-1:0] cw;
        cw    = {d[3], d[2], d[1], 1'b0, d[0], 1'b0, 1'b0};
        // Parity slots are still zero here, so each reduction sees only data bits.
        cw[0] = ^(cw & P1_MASK);
        cw[1] = ^(cw & P2_MASK);
        cw[3] = ^(cw & P4_MASK);
        return cw;
    endfunction

endpackage

// File: rtl/hamming74_encoder_tx_if.sv
// Producer-side handshake for the Hamming(7,4) serial transmitter: nibble,
// valid/ready and the per-nibble error-injection request.
interface hamming74_encoder_tx_if;
    import hamming_pkg::*;

    logic [DATA_BITS-1:0] data_in;
    logic                 data_valid;
    logic                 data_ready;
    logic                 inject_en;
    logic [2:0]           inject_pos;

    modport master (
        output data_in,
        output data_valid,
        output inject_en,
        output inject_pos,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  inject_en,
        input  inject_pos,
        output data_ready
    );

endinterface

// File: rtl/hamming74_encode_comb.sv
// Combinational Hamming(7,4) encoder with an optional single-bit flip;
// flip_pos values 0..6 select a codeword bit, 7 leaves the codeword clean.
module hamming74_encode_comb
    import hamming_pkg::*;
(
    input  logic [DATA_BITS-1:0] data,
    input  logic [2:0]           flip_pos,
    output logic [CW_BITS-1:0]   cw
);

    logic [CW_BITS-1:0] clean_cw;

    assign clean_cw = hamming74_encode(data);

    genvar gi;
    generate
        for (gi = 0; gi < CW_BITS; gi++) begin : g_flip
            assign cw[gi] = clean_cw[gi] ^ (flip_pos == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/hamming74_encoder_tx.sv
// Hamming(7,4) serial transmitter: one-entry holding register, encode at load,
// LSB-first shift-out framed as 7 data slots plus GAP_CYCLES idle slots.
module hamming74_encoder_tx
    import hamming_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    hamming74_encoder_tx_if.slave   in_if,
    output logic                    ser_out,
    output logic                    frame_start,
    output logic                    busy,
    output logic [2:0]              slot_cnt
);

    // Gap slots reuse slot_cnt (7,0,1,...), so the last gap slot has this index.
    localparam logic [2:0] GAP_LAST = 3'((GAP_CYCLES + 6) % 8);

    state_t               state_q, state_d;
    logic [2:0]           slot_cnt_q, slot_cnt_d;
    logic [CW_BITS-1:0]   shreg_q, shreg_d;
    logic                 ser_out_q, ser_out_d;
    logic                 frame_start_q, frame_start_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic [2:0]           hold_flip_q, hold_flip_d;

    logic [CW_BITS-1:0]   load_cw;
    logic [2:0]           slot_inc;
    logic                 accept;
    logic                 load;
    logic                 go_idle;

    hamming74_encode_comb u_encode (
        .data     (hold_data_q),
        .flip_pos (hold_flip_q),
        .cw       (load_cw)
    );

    assign in_if.data_ready = !hold_full_q;
    assign accept           = in_if.data_valid && !hold_full_q;
    assign slot_inc         = slot_cnt_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        slot_cnt_d    = slot_cnt_q;
        shreg_d       = shreg_q;
        ser_out_d     = ser_out_q;
        frame_start_d = frame_start_q;
        load          = 1'b0;
        go_idle       = 1'b0;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    ser_out_d     = IDLE_LEVEL;
                    frame_start_d = 1'b0;
                    load          = hold_full_q;
                end
                SEND: begin
                    if (slot_cnt_q == 3'd6) begin
                        if (GAP_CYCLES > 0) begin
                            state_d       = GAP;
                            slot_cnt_d    = 3'd7;
                            ser_out_d     = IDLE_LEVEL;
                            frame_start_d = 1'b0;
                        end else begin
                            load    = hold_full_q;
                            go_idle = !hold_full_q;
                        end
                    end else begin
                        slot_cnt_d    = slot_inc;
                        ser_out_d     = shreg_q[slot_inc];
                        frame_start_d = 1'b0;
                    end
                end
                GAP: begin
                    if (slot_cnt_q == GAP_LAST) begin
                        load    = hold_full_q;
                        go_idle = !hold_full_q;
                    end else begin
                        slot_cnt_d = slot_inc;
                    end
                end
                default: go_idle = 1'b1;
            endcase
        end

        // Loading drives bit 0 straight into the output register so the frame
        // starts on the same edge the codeword enters the shift register.
        if (load) begin
            state_d       = SEND;
            shreg_d       = load_cw;
            slot_cnt_d    = 3'd0;
            ser_out_d     = load_cw[0];
            frame_start_d = 1'b1;
        end else if (go_idle) begin
            state_d       = IDLE;
            slot_cnt_d    = 3'd0;
            ser_out_d     = IDLE_LEVEL;
            frame_start_d = 1'b0;
        end
    end

    // The input stage ignores ena; a same-edge accept and load keeps hold full.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_flip_d = hold_flip_q;
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = in_if.data_in;
            hold_flip_d = in_if.inject_en ? in_if.inject_pos : 3'd7;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            slot_cnt_q    <= 3'd0;
            shreg_q       <= '0;
            ser_out_q     <= IDLE_LEVEL;
            frame_start_q <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_data_q   <= '0;
            hold_flip_q   <= 3'd7;
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            shreg_q       <= shreg_d;
            ser_out_q     <= ser_out_d;
            frame_start_q <= frame_start_d;
            hold_full_q   <= hold_full_d;
            hold_data_q   <= hold_data_d;
            hold_flip_q   <= hold_flip_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != IDLE);
    assign slot_cnt    = slot_cnt_q;

endmodule

// File: doc/hamming74_encoder_tx.md
Name: hamming74_encoder_tx

Overview:
- Upstream neighbour of the serial Hamming(7,4) decoder.
- Accepts 4-bit nibbles through a valid/ready handshake and computes the 7-bit codeword.
- Shifts the codeword out LSB-first, one bit per enabled clock, framed into 7 + GAP_CYCLES slots. With the default of one gap slot, this matches the decoder's 8-slot collect/decode cycle.
- Optional single-bit error injection lets the decoder's correction path be exercised.

Parameters:
- GAP_CYCLES, 1, idle slots after bit 6 of each frame (legal range 0..7).
- IDLE_LEVEL, 0, level driven on ser_out when no codeword bit is being sent.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  bit-slot enable; all state advances only when ena=1.
- data_in  in  4  nibble d[3:0].
- data_valid  in  1  producer has a nibble.
- data_ready  out  1  holding register empty; transfer when data_valid & data_ready on a clock edge.
- inject_en  in  1  corrupt the next loaded codeword.
- inject_pos  in  3  codeword bit to flip (0..6; value 7 = no flip).
- ser_out  out  1  serial codeword bit.
- frame_start  out  1  high during bit-0 slot of a frame.
- busy  out  1  FSM not in IDLE.
- slot_cnt  out  3  current bit index inside a frame (debug).

Behaviour:
- Reset (async, rst=1). Outputs and state go to:
  - ser_out=IDLE_LEVEL, frame_start=0, busy=0, slot_cnt=0, data_ready=1.
  - Holding register empty, FSM=IDLE, inject flag clear.
- Codeword layout (bit index = send order, position p = index+1):
  - c0=p1=d0^d1^d3, c1=p2=d0^d2^d3, c2=d0, c3=p4=d1^d2^d3, c4=d1, c5=d2, c6=d3.
  - Decoder syndrome therefore equals the 1-based error position.
- Input stage:
  - One-entry holding register; data_ready = !hold_full. Not gated by ena.
  - Accept: data_in and the latched inject request (inject_en, inject_pos) are captured together.
  - Simultaneous accept and FSM load in the same cycle is legal. The new nibble lands in hold and the old one moves to the shift register.
- Output is registered; all FSM state below advances only on edges where ena=1.
- FSM states and transitions:
  - IDLE: ser_out=IDLE_LEVEL. If hold_full: load the encoded codeword (with the optional flip applied) into a 7-bit shift register, clear hold, slot_cnt=0, go to SEND.
  - SEND: ser_out=shreg[slot_cnt]; frame_start=(slot_cnt==0). slot_cnt increments each enabled cycle.
    - After slot 6: go to GAP if GAP_CYCLES>0.
    - If GAP_CYCLES=0: load the next frame back-to-back if hold_full, else go to IDLE.
  - GAP: ser_out=IDLE_LEVEL; slot_cnt continues 7,0,1,... counting gap slots.
    - After GAP_CYCLES slots: if hold_full, load and go to SEND; else go to IDLE.
- Latency: a nibble accepted into an idle block appears as bit 0 on ser_out two enabled edges later (hold, load → ser_out register).
- ena=0: FSM, slot_cnt, ser_out and frame_start hold their values; nothing advances mid-frame.
- Error injection:
  - The flip is applied once, at load time, to the codeword of the nibble captured with inject_en=1.
  - inject_pos=7 is a no-op.
  - Subsequent frames are clean unless requested again.
- Reset mid-frame: frame is aborted and ser_out returns to IDLE_LEVEL immediately (async); the held nibble is discarded.

Decomposition:
- Shared package (hamming_pkg) holds:
  - constants CW_BITS=7 and DATA_BITS=4;
  - parity-position masks P1_MASK=7'b1010101, P2_MASK=7'b1100110, P4_MASK=7'b1111000;
  - FSM state encoding {IDLE, SEND, GAP};
  - a function hamming74_encode(d) returning the 7-bit codeword, reused by the decoder bench model.
- One sub-module: hamming74_encode_comb (pure combinational encoder plus inject flip), instantiated once at the load point.

Test Plan:
- Single nibble 4'b1011, ena=1, GAP=1:
  - Expected codeword 7'b1010101, so ser_out sequence is 1,0,1,0,1,0,1 followed by IDLE_LEVEL.
  - frame_start high only at slot 0; busy drops after the gap.
- Back-to-back 4'h0 then 4'hF with data_valid held:
  - Frames are separated by exactly GAP_CYCLES idle slots; 4'hF sends 1111111.
  - data_ready deasserts only while hold is full.
- ena toggled 1,0,0,1 mid-frame on 4'h6 (codeword 7'b0110011): the bit sequence is unchanged and each stalled slot is stretched, with no bit lost or duplicated.
- inject_en=1, inject_pos=4 with 4'h6: frame sends 7'b0100011. The next frame, 4'h6 with inject_en=0, is clean. Loopback into the decoder gives syndrome 5 and corrected data 6.
- Assert rst at slot 3 of a frame:
  - ser_out=IDLE_LEVEL, busy=0, data_ready=1 asynchronously.
  - After release, a new nibble 4'h9 sends 7'b1001100 from slot 0.
- GAP_CYCLES=0 with a continuous stream of 16 nibbles 0..F: 112 contiguous bits, each 7-bit group matches hamming74_encode.
